// File: rtl/input_debouncer.sv
// Debouncer for a bounce-prone asynchronous input: synchronizer, confirm FSM,
// registered level with rise/fall pulses, and a saturating count of rejected changes.
//
// state      | meaning
// STABLE_LO  | accepted level 0, waiting for a synchronized 1
// CONFIRM_HI | counting consecutive 1 samples before accepting the rise
// STABLE_HI  | accepted level 1, waiting for a synchronized 0
// CONFIRM_LO | counting consecutive 0 samples before accepting the fall
module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a,
    input  logic                glitch_clr,
    output logic                level,
    output logic                rise,
    output logic                fall,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO  = 2'd0,
        CONFIRM_HI = 2'd1,
        STABLE_HI  = 2'd2,
        CONFIRM_LO = 2'd3
    } state_t;

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
            $error("input_debouncer: SYNC_STAGES must be 2..4");
        end
        if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_deb
            $error("input_debouncer: DEBOUNCE_CYCLES must be 1..255");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   a_sync;
    state_t                 state;
    logic [CW-1:0]          cnt;
    logic                   glitch_ev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], a};
        end
    end

    assign a_sync = sync_q[SYNC_STAGES-1];

    // A rejected change is a confirm phase broken by the opposite sample.
    assign glitch_ev = ((state == CONFIRM_HI) && !a_sync) ||
                       ((state == CONFIRM_LO) &&  a_sync);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= STABLE_LO;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                STABLE_LO: begin
                    if (a_sync) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state <= STABLE_HI;
                            level <= 1'b1;
                            rise  <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            state <= CONFIRM_HI;
                            cnt   <= CNT_ONE;
                        end
                    end
                end
                CONFIRM_HI: begin
                    if (a_sync) begin
                        if (cnt == CNT_LAST) begin
                            state <= STABLE_HI;
                            level <= 1'b1;
                            rise  <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end else begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                    end
                end
                STABLE_HI: begin
                    if (!a_sync) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state <= STABLE_LO;
                            level <= 1'b0;
                            fall  <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            state <= CONFIRM_LO;
                            cnt   <= CNT_ONE;
                        end
                    end
                end
                CONFIRM_LO: begin
                    if (!a_sync) begin
                        if (cnt == CNT_LAST) begin
                            state <= STABLE_LO;
                            level <= 1'b0;
                            fall  <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end else begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= STABLE_LO;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

    // Clear wins over a coincident glitch; the count sticks at all ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            glitch_cnt <= '0;
        end else if (glitch_clr) begin
            glitch_cnt <= '0;
        end else if (glitch_ev && (glitch_cnt != {GLITCH_W{1'b1}})) begin
            glitch_cnt <= glitch_cnt + 1'b1;
        end
    end

    a_no_both_edges: assert property (@(posedge clk) disable iff (!rst) !(rise && fall));
    a_rise_level:    assert property (@(posedge clk) disable iff (!rst) rise |-> level);
    a_fall_level:    assert property (@(posedge clk) disable iff (!rst) fall |-> !level);

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer at default parameters: table of per-cycle
// vectors plus hand-written reset, saturation and clear sequences.
module tb_input_debouncer;

    logic       clk;
    logic       rst;
    logic       a;
    logic       glitch_clr;
    logic       level;
    logic       rise;
    logic       fall;
    logic [7:0] glitch_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       a;
        logic       clr;
        logic       lvl;
        logic       r;
        logic       f;
        logic [7:0] gc;
    } vec_t;

    vec_t vecs[$];

    input_debouncer #(
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .GLITCH_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .a(a),
        .glitch_clr(glitch_clr),
        .level(level),
        .rise(rise),
        .fall(fall),
        .glitch_cnt(glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic va, input logic vc, input logic vl,
                                input logic vr, input logic vf, input logic [7:0] vg);
        vec_t v;
        v.a = va; v.clr = vc; v.lvl = vl; v.r = vr; v.f = vf; v.gc = vg;
        vecs.push_back(v);
    endfunction

    initial begin
        // From STABLE_HI: held fall, accepted on the 6th edge
        for (int i = 1; i <= 7; i++) add(1'b0, 1'b0, (i < 6), 1'b0, (i == 6), 8'd0);
        // Two-cycle high pulse: rejected, counted on the 5th edge
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int i = 3; i <= 6; i++) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (i >= 5) ? 8'd1 : 8'd0);
        // Held rise
        for (int i = 1; i <= 7; i++) add(1'b1, 1'b0, (i >= 6), (i == 6), 1'b0, 8'd1);
        // Two-cycle low pulse from STABLE_HI: rejected
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
        for (int i = 3; i <= 6; i++) add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, (i >= 5) ? 8'd2 : 8'd1);
        // Plain clear
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        // Back to low
        for (int i = 1; i <= 7; i++) add(1'b0, 1'b0, (i < 6), 1'b0, (i == 6), 8'd0);

        // Reset held with a=1: all outputs low
        rst = 1'b0; a = 1'b1; glitch_clr = 1'b0;
        tick(); tick(); tick();
        chk("rst_level", level, 1'b0);
        chk("rst_rise", rise, 1'b0);
        chk("rst_fall", fall, 1'b0);
        chk("rst_gcnt", glitch_cnt, 8'd0);
        rst = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk($sformatf("post_rst_level_e%0d", e), level, (e >= 6));
            chk($sformatf("post_rst_rise_e%0d", e), rise, (e == 6));
            chk($sformatf("post_rst_fall_e%0d", e), fall, 1'b0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            a = vecs[i].a;
            glitch_clr = vecs[i].clr;
            tick();
            chk($sformatf("vec%0d_level", i), level, vecs[i].lvl);
            chk($sformatf("vec%0d_rise", i), rise, vecs[i].r);
            chk($sformatf("vec%0d_fall", i), fall, vecs[i].f);
            chk($sformatf("vec%0d_gcnt", i), glitch_cnt, vecs[i].gc);
        end
        glitch_clr = 1'b0;

        // 260 single-cycle glitches: count saturates at 255
        for (int g = 1; g <= 260; g++) begin
            a = 1'b1; tick();
            a = 1'b0; tick(); tick(); tick();
            if (g == 3) chk("gcnt_after_3", glitch_cnt, 8'd3);
            if (g == 255) chk("gcnt_sat_255", glitch_cnt, 8'd255);
        end
        chk("gcnt_held_260", glitch_cnt, 8'd255);
        chk("gcnt_level_low", level, 1'b0);

        // Clear coincident with a glitch
        a = 1'b1; tick();
        a = 1'b0; tick(); tick();
        glitch_clr = 1'b1; tick();
        glitch_clr = 1'b0;
        chk("clr_with_glitch", glitch_cnt, 8'd0);

        // Async reset while level=1 and glitch_cnt>0
        a = 1'b1;
        for (int e = 0; e < 7; e++) tick();
        a = 1'b0; tick();
        a = 1'b1; tick(); tick(); tick();
        chk("pre_rst_level", level, 1'b1);
        chk("pre_rst_gcnt", glitch_cnt, 8'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_level", level, 1'b0);
        chk("async_rst_gcnt", glitch_cnt, 8'd0);
        a = 1'b0;
        #2 rst = 1'b1;
        tick(); tick(); tick();

        // Reset in CONFIRM_HI with cnt=2: abandoned, no glitch counted
        a = 1'b1; tick();
        a = 1'b0; tick(); tick(); tick();
        chk("pre_cfm_gcnt", glitch_cnt, 8'd1);
        a = 1'b1;
        tick(); tick(); tick(); tick();
        chk("cfm_level_low", level, 1'b0);
        a = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("cfm_rst_level", level, 1'b0);
        chk("cfm_rst_rise", rise, 1'b0);
        chk("cfm_rst_fall", fall, 1'b0);
        chk("cfm_rst_gcnt", glitch_cnt, 8'd0);
        #2 rst = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            chk($sformatf("cfm_after_rise_e%0d", e), rise, 1'b0);
            chk($sformatf("cfm_after_gcnt_e%0d", e), glitch_cnt, 8'd0);
            chk($sformatf("cfm_after_level_e%0d", e), level, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
